// File: rtl/line_mux_arbiter.sv
// line_mux_arbiter
// Two-line-to-one merge with packet-aware round-robin arbitration.
// Once a line's first beat is accepted, the grant stays on that line until
// its last beat is accepted, so packets from the two lines never interleave.
// The merged line is driven from a single registered output entry.
//
// Ports:
//   clk, rst                      clock (rising edge), async active-high reset
//   in0_data/valid/last/ready     producer line 0 (valid/ready handshake)
//   in1_data/valid/last/ready     producer line 1 (valid/ready handshake)
//   out_data/valid/last           merged registered output line
//   out_ready                     downstream accept
//   out_sel                       source line of the held beat; present only
//                                 when LINE_MUX_SEL_OUT_EN is defined
//
// Parameter: DATA_W  width of every data line.
// Optional macro: LINE_MUX_SEL_OUT_EN adds the out_sel output.
module line_mux_arbiter #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in0_data,
    input  logic              in0_valid,
    input  logic              in0_last,
    output logic              in0_ready,
    input  logic [DATA_W-1:0] in1_data,
    input  logic              in1_valid,
    input  logic              in1_last,
    output logic              in1_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
`ifdef LINE_MUX_SEL_OUT_EN
    input  logic              out_ready,
    output logic              out_sel
`else
    input  logic              out_ready
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              rr_ptr;

    logic              grant;
    logic              load_ok;
    logic              acc;
    logic              acc_last;
    logic [DATA_W-1:0] acc_data;

    logic [DATA_W-1:0] data_p1;
    logic              last_p1;
    logic              vld_p1;
`ifdef LINE_MUX_SEL_OUT_EN
    logic              sel_p1;
`endif

    // ---- stage 0: arbitration and input handshake ----
    // In IDLE a lone valid line wins outright; otherwise rr_ptr decides, which
    // also keeps a stable grant when nothing is valid.
    always_comb begin
        grant = rr_ptr;
        case (state)
            IDLE: begin
                if (in0_valid && !in1_valid)
                    grant = 1'b0;
                else if (in1_valid && !in0_valid)
                    grant = 1'b1;
            end
            LOCK0:   grant = 1'b0;
            LOCK1:   grant = 1'b1;
            default: grant = rr_ptr;
        endcase
    end

    // The output entry can take a beat when empty or draining this cycle.
    assign load_ok   = !vld_p1 || out_ready;
    assign in0_ready = !grant && load_ok;
    assign in1_ready = grant && load_ok;

    assign acc      = grant ? (in1_valid && in1_ready) : (in0_valid && in0_ready);
    assign acc_last = grant ? in1_last : in0_last;
    assign acc_data = grant ? in1_data : in0_data;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (acc && !acc_last)
                    state_nxt = grant ? LOCK1 : LOCK0;
            end
            LOCK0, LOCK1: begin
                if (acc && acc_last)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= 1'b0;
        end else begin
            state <= state_nxt;
            if (acc && acc_last)
                rr_ptr <= !grant;
        end
    end

    // ---- stage 1: registered output entry ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            last_p1 <= 1'b0;
`ifdef LINE_MUX_SEL_OUT_EN
            sel_p1  <= 1'b0;
`endif
        end else if (acc) begin
            vld_p1  <= 1'b1;
            data_p1 <= acc_data;
            last_p1 <= acc_last;
`ifdef LINE_MUX_SEL_OUT_EN
            sel_p1  <= grant;
`endif
        end else if (out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign out_data  = data_p1;
    assign out_last  = last_p1;
    assign out_valid = vld_p1;
`ifdef LINE_MUX_SEL_OUT_EN
    assign out_sel   = sel_p1;
`endif

endmodule

// File: tb/tb_line_mux_arbiter.sv
// tb_line_mux_arbiter
// Directed steps followed by randomized packet traffic for line_mux_arbiter.
// The reference for the random phase is the packet-level rule: with both
// producers holding their next packet ready at every packet boundary, the
// merged stream is line0 pkt0, line1 pkt0, line0 pkt1, line1 pkt1, ...
module tb_line_mux_arbiter;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       first;
        logic       line;
    } beat_t;

    logic       clk;
    logic       rst;
    logic [7:0] in0_data;
    logic       in0_valid;
    logic       in0_last;
    logic       in0_ready;
    logic [7:0] in1_data;
    logic       in1_valid;
    logic       in1_last;
    logic       in1_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       out_ready;
`ifdef LINE_MUX_SEL_OUT_EN
    logic       out_sel;
`endif

    int total = 0;
    int bad   = 0;

    beat_t q0[$];
    beat_t q1[$];
    beat_t expq[$];
    logic  gate0, gate1, ordy_set;
    logic  hs0, hs1, ohs;

    line_mux_arbiter #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in0_data  (in0_data),
        .in0_valid (in0_valid),
        .in0_last  (in0_last),
        .in0_ready (in0_ready),
        .in1_data  (in1_data),
        .in1_valid (in1_valid),
        .in1_last  (in1_last),
        .in1_ready (in1_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
`ifdef LINE_MUX_SEL_OUT_EN
        .out_ready (out_ready),
        .out_sel   (out_sel)
`else
        .out_ready (out_ready)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Producers present the head of their queue; a non-first beat may be
    // withheld by the gate to create mid-packet bubbles.
    task automatic drive();
        in0_valid = (q0.size() > 0) && (q0[0].first || gate0);
        in0_data  = (q0.size() > 0) ? q0[0].data : 8'h00;
        in0_last  = (q0.size() > 0) ? q0[0].last : 1'b0;
        in1_valid = (q1.size() > 0) && (q1[0].first || gate1);
        in1_data  = (q1.size() > 0) ? q1[0].data : 8'h00;
        in1_last  = (q1.size() > 0) ? q1[0].last : 1'b0;
        out_ready = ordy_set;
    endtask

    task automatic sample();
        hs0 = in0_valid && in0_ready;
        hs1 = in1_valid && in1_ready;
        ohs = out_valid && out_ready;
    endtask

    // One clock: retire handshaken beats, drive the next inputs just after the
    // edge, then stop at the falling edge where outputs are observed.
    task automatic tick();
        @(posedge clk);
        #1;
        if (hs0) void'(q0.pop_front());
        if (hs1) void'(q1.pop_front());
        drive();
        @(negedge clk);
        sample();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        q0.delete();
        q1.delete();
        gate0 = 1'b1;
        gate1 = 1'b1;
        ordy_set = 1'b1;
        drive();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        sample();
    endtask

    function automatic beat_t mk(input logic [7:0] d, input logic l, input logic f, input logic ln);
        beat_t b;
        b.data  = d;
        b.last  = l;
        b.first = f;
        b.line  = ln;
        return b;
    endfunction

    initial begin
        logic [7:0] e;
        logic [7:0] held_data;
        logic       held;
        int         len;
        rst = 1'b1;
        gate0 = 1'b1;
        gate1 = 1'b1;
        ordy_set = 1'b1;
        hs0 = 1'b0;
        hs1 = 1'b0;
        ohs = 1'b0;
        drive();
        #12;

        // Reset release with no traffic: empty output, line 0 preferred.
        do_reset();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_in0_ready", 32'(in0_ready), 32'd1);
        chk("rst_in1_ready", 32'(in1_ready), 32'd0);
`ifdef LINE_MUX_SEL_OUT_EN
        chk("rst_out_sel",   32'(out_sel),   32'd0);
`endif

        // Single-beat packets on both lines: strict alternation, 1 beat/cycle.
        for (int i = 0; i < 8; i++) begin
            q0.push_back(mk(8'hA0 + 8'(i), 1'b1, 1'b1, 1'b0));
            q1.push_back(mk(8'hB0 + 8'(i), 1'b1, 1'b1, 1'b1));
        end
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("alt_in0_ready", 32'(in0_ready), 32'(((k - 1) % 2) == 0));
            if (k >= 2) begin
                e = ((k - 2) % 2 == 0) ? 8'hA0 + 8'((k - 2) / 2) : 8'hB0 + 8'((k - 2) / 2);
                chk("alt_out_valid", 32'(out_valid), 32'd1);
                chk("alt_out_data",  32'(out_data),  32'(e));
`ifdef LINE_MUX_SEL_OUT_EN
                chk("alt_out_sel",   32'(out_sel),   32'((k - 2) % 2));
`endif
            end
        end

        // Three-beat packet on line 0 holds off a waiting line 1.
        do_reset();
        q0.push_back(mk(8'h11, 1'b0, 1'b1, 1'b0));
        q0.push_back(mk(8'h12, 1'b0, 1'b0, 1'b0));
        q0.push_back(mk(8'h13, 1'b1, 1'b0, 1'b0));
        q1.push_back(mk(8'h21, 1'b1, 1'b1, 1'b1));
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k <= 4) chk("pkt_in1_ready", 32'(in1_ready), 32'(k >= 4));
            if (k >= 2) begin
                case (k)
                    2: e = 8'h11;
                    3: e = 8'h12;
                    4: e = 8'h13;
                    default: e = 8'h21;
                endcase
                chk("pkt_out_data", 32'(out_data), 32'(e));
                chk("pkt_out_last", 32'(out_last), 32'(k >= 4));
            end
        end

        // Output backpressure: held beat stays put, no readies.
        do_reset();
        q0.push_back(mk(8'h5C, 1'b1, 1'b1, 1'b0));
        q0.push_back(mk(8'h5D, 1'b1, 1'b1, 1'b0));
        tick();
        ordy_set = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_out_data",  32'(out_data),  32'h5C);
            chk("bp_in0_ready", 32'(in0_ready), 32'd0);
            chk("bp_in1_ready", 32'(in1_ready), 32'd0);
        end
        ordy_set = 1'b1;
        tick();
        chk("bp_drain_ready", 32'(in0_ready), 32'd1);
        chk("bp_drain_data",  32'(out_data),  32'h5C);
        tick();
        chk("bp_next_data",   32'(out_data),  32'h5D);
        chk("bp_next_valid",  32'(out_valid), 32'd1);

        // Asynchronous reset while locked on line 1.
        do_reset();
        q1.push_back(mk(8'h31, 1'b0, 1'b1, 1'b1));
        q1.push_back(mk(8'h32, 1'b0, 1'b0, 1'b1));
        q1.push_back(mk(8'h33, 1'b1, 1'b0, 1'b1));
        tick();
        tick();
        chk("lock1_out_data", 32'(out_data), 32'h31);
        chk("lock1_in0_ready", 32'(in0_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        do_reset();
        q0.push_back(mk(8'h41, 1'b1, 1'b1, 1'b0));
        q1.push_back(mk(8'h51, 1'b1, 1'b1, 1'b1));
        tick();
        chk("post_rst_in0_ready", 32'(in0_ready), 32'd1);
        chk("post_rst_in1_ready", 32'(in1_ready), 32'd0);
        tick();
        chk("post_rst_out_data",  32'(out_data),  32'h41);

        // Random packets, bubbles and backpressure against the packet-order model.
        do_reset();
        expq.delete();
        for (int p = 0; p < 20; p++) begin
            for (int ln = 0; ln < 2; ln++) begin
                len = $urandom_range(1, 4);
                for (int b = 0; b < len; b++) begin
                    if (ln == 0) q0.push_back(mk(8'($urandom), b == len - 1, b == 0, 1'b0));
                    else         q1.push_back(mk(8'($urandom), b == len - 1, b == 0, 1'b1));
                    expq.push_back(ln == 0 ? q0[q0.size() - 1] : q1[q1.size() - 1]);
                end
            end
        end
        held = 1'b0;
        held_data = 8'h00;
        for (int t = 0; t < 3000 && expq.size() > 0; t++) begin
            gate0 = 1'($urandom_range(0, 1));
            gate1 = 1'($urandom_range(0, 1));
            ordy_set = ($urandom_range(0, 3) != 0);
            tick();
            chk("rnd_one_ready", 32'(in0_ready && in1_ready), 32'd0);
            if (held) begin
                chk("rnd_hold_valid", 32'(out_valid), 32'd1);
                chk("rnd_hold_data",  32'(out_data),  32'(held_data));
            end
            if (out_valid && !out_ready)
                chk("rnd_bp_ready", 32'(in0_ready || in1_ready), 32'd0);
            held = out_valid && !out_ready;
            held_data = out_data;
            if (ohs) begin
                if (expq.size() == 0) begin
                    chk("rnd_extra_beat", 32'd1, 32'd0);
                end else begin
                    chk("rnd_data", 32'(out_data), 32'(expq[0].data));
                    chk("rnd_last", 32'(out_last), 32'(expq[0].last));
`ifdef LINE_MUX_SEL_OUT_EN
                    chk("rnd_sel",  32'(out_sel),  32'(expq[0].line));
`endif
                    void'(expq.pop_front());
                end
            end
        end
        chk("rnd_drained", 32'(expq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/line_mux_arbiter.md
Name: line_mux_arbiter

Overview:
- Two-line-to-one multiplexer with packet-aware round-robin arbitration and valid/ready handshakes on every line.
- Merges two producer lines (line 0, line 1) onto one registered output line for the downstream de-multiplexing stage.
- Grant is held for the full packet, so beats from the two lines never interleave inside a packet.

Parameters:
- DATA_W, 8, width of every data line in bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active high.
- in0_data  input  DATA_W  line 0 data.
- in0_valid  input  1  line 0 beat present.
- in0_last  input  1  line 0 final beat of packet.
- in0_ready  output  1  line 0 beat accepted this cycle when valid&ready.
- in1_data  input  DATA_W  line 1 data.
- in1_valid  input  1  line 1 beat present.
- in1_last  input  1  line 1 final beat of packet.
- in1_ready  output  1  line 1 beat accepted this cycle when valid&ready.
- out_data  output  DATA_W  merged line data, registered.
- out_valid  output  1  merged beat present, registered.
- out_last  output  1  merged final beat, registered.
- out_ready  input  1  downstream accepts beat.

Behaviour:
- Reset (async, rst=1): out_valid=0, out_data=0, out_last=0, state=IDLE, rr_ptr=0 (line 0 preferred). Effect is immediate, without waiting for clk. Reset mid-packet discards the lock and the held beat.
- Output register: one entry. load_ok = !out_valid | out_ready. Combinational path from out_ready to inX_ready is allowed.
- inX_ready = grantX & load_ok. Never depends on inX_valid. Only one ready is high at a time.
- Accept on valid&ready at a clk edge. The register takes data and last, and out_valid becomes 1. Latency is 1 cycle.
- If out_valid&out_ready and no new accept, out_valid goes to 0.
- Full throughput: 1 beat/cycle while out_ready stays high.
- States:
  - IDLE: grant the only valid line. If both are valid, grant line rr_ptr. If none is valid, grant line rr_ptr, but ready has no effect.
  - LOCK0 / LOCK1: grant only the locked line. The other line's ready stays 0 even if it is valid.
- Transitions:
  - IDLE -> LOCKx on accept from x with last=0.
  - LOCKx -> IDLE on accept from x with last=1.
  - IDLE -> IDLE on accept with last=1 (single-beat packet).
- rr_ptr update: on every accept with last=1 from line x, rr_ptr <= !x.
- Output backpressure (out_valid=1, out_ready=0): all readies are 0, and out_data, out_last and out_valid hold stable.
- Valid deasserted mid-packet in LOCKx: stay in LOCKx and wait. No timeout.

Optional Feature:
- Macro: LINE_MUX_SEL_OUT_EN.
- Defined: adds port out_sel (output, 1). It is registered with out_data, equals the source line of the held beat, and resets to 0. This lets the downstream demux route the beat back.
- Undefined: port absent. Behaviour otherwise identical.

Test Plan:
- Reset release, no valids -> out_valid=0, out_data=0, in0_ready=1, in1_ready=0 (rr_ptr=0, load_ok=1).
- Both lines valid every cycle with single-beat packets (last=1), in0_data=0xA0.., in1_data=0xB0.., out_ready=1 -> output alternates 0xA0,0xB0,0xA1,0xB1..., one beat per cycle, first beat 1 cycle after first accept.
- Line 0 sends a 3-beat packet (0x11,0x12,0x13 last) while line 1 is valid throughout -> in1_ready=0 until 0x13 is accepted. Output is 0x11,0x12,0x13 then line 1's beat. out_last=1 only on 0x13.
- out_ready held 0 for 4 cycles with out_valid=1, data 0x5C -> out_data stays 0x5C, in0_ready=in1_ready=0. out_ready=1 -> next beat loads the same cycle the held beat drains.
- Assert rst mid-packet in LOCK1 -> out_valid drops without waiting for clk. After release, a line 0 single beat is granted first.
- With LINE_MUX_SEL_OUT_EN defined, alternating traffic -> out_sel toggles 0,1,0,1 aligned with out_data. out_sel=0 after reset.
